serial_shift_ctrl: RTL
======================

Name: serial_shift_ctrl

Overview:
- Frame controller that runs the team's Shiftreg primitive as an SPI-mode-0 style full-duplex serial engine.
- Accepts a parallel word over a valid/ready handshake and loads the shift register.
- Generates a divided serial clock and frame strobe, shifts WIDTH bits out while sampling WIDTH bits in, then returns the received word with a one-cycle valid.
- Sits between register-level logic and off-chip serial devices on the CMD3 boards.

Parameters:
- WIDTH, 8: bits per frame; legal range 2..32.
- DIV, 2: clk cycles per sclk half-period; legal range 1..255.
- DIRECTION, 0: shift order; 0 = MSB first, 1 = LSB first (same encoding as Shiftreg).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start_valid  in  1  request to send tx_data.
- start_ready  out  1  controller can accept a request.
- tx_data  in  WIDTH  word to transmit; sampled on the accept edge only.
- abort  in  1  synchronous frame kill.
- sclk  out  1  serial clock; idles low.
- sdo  out  1  serial data out.
- sdi  in  1  serial data in; already synchronised externally.
- frame  out  1  active-high frame strobe (chip-select).
- busy  out  1  high in every state except IDLE.
- rx_data  out  WIDTH  last received word; holds until the next DONE.
- rx_valid  out  1  one-cycle pulse when rx_data updates.

Behaviour:
Reset (clr = 1, any time, including mid-frame):
- state = IDLE; all counters = 0; tx and rx shift registers = 0.
- sclk = 0, sdo = 0, frame = 0, busy = 0, rx_valid = 0, rx_data = 0, start_ready = 1 on the first clk after release.

Handshake:
- Accept occurs when start_valid && start_ready.
- start_ready = (state == IDLE) && !abort.
- On the accept edge: tx shift register <= tx_data, bit_cnt <= 0, div_cnt <= 0, state <= LOW.

States:
- LOW: sclk = 0, frame = 1. sdo shows the current head bit (MSB for DIRECTION 0, LSB for DIRECTION 1). Stay DIV cycles, then go to HIGH.
- HIGH: sclk = 1, frame = 1.
  - On the entry edge, sdi shifts into the rx register tail.
  - Stay DIV cycles.
  - If bit_cnt == WIDTH-1, go to HOLD.
  - Otherwise bit_cnt++, the tx register shifts one place (vacated bit filled with 0), and go to LOW. sdo therefore changes only when sclk falls.
- HOLD: sclk = 0, frame = 1, sdo = 0. Stay DIV cycles (CS hold time), then go to DONE.
- DONE: frame = 0, rx_data <= rx register, rx_valid = 1 for exactly this cycle, then go to IDLE.

Timing:
- Frame length is 2*DIV*WIDTH + DIV cycles.
- rx_valid rises 2*DIV*WIDTH + DIV + 1 cycles after the accept edge.
- The earliest next accept is 2 cycles after the rx_valid cycle.
- Received word equals the sdi bits in arrival order, packed according to DIRECTION.

Divider:
- div_cnt counts 0..DIV-1 and resets at every state change.
- Width is $clog2(DIV+1).
- DIV = 1 gives sclk = clk/2.

Abort:
- In LOW, HIGH or HOLD, abort = 1 forces state <= IDLE on the next edge.
- sclk = 0 and frame = 0 on that edge; no rx_valid pulse; rx_data is unchanged.
- abort in IDLE or DONE is ignored, except that it masks start_ready in IDLE.

Other boundary rules:
- start_valid while busy is ignored; the request is not queued.
- tx_data changes after accept have no effect on the frame in progress.
- Simultaneous abort and start_valid in IDLE: no accept.

Decomposition:
- Package serial_shift_ctrl_pkg holds:
  - typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, DONE} state_t;
  - DIR_MSB_FIRST = 0 and DIR_LSB_FIRST = 1 constants.
- The tx and rx registers are two instances of the existing Shiftreg primitive, driven as follows:
  - DIRECTION passed through.
  - clrn tied to ~clr.
  - load strobed on the accept edge.
  - en strobed at the end of HIGH (tx) or on HIGH entry (rx).
- bit_cnt, div_cnt and the FSM stay inline; no other sub-module.

Test Plan:
1. Reset, WIDTH = 8, DIV = 2, DIRECTION = 0, tx_data = 0xA5, sdi looped to sdo → sdo bit sequence 1,0,1,0,0,1,0,1; frame high for 34 cycles; rx_valid single pulse 35 cycles after accept; rx_data = 0xA5.
2. DIRECTION = 1, tx_data = 0x01, sdi tied 1 → sdo = 1 on first LOW, then 0 for the remaining bits; rx_data = 0xFF.
3. DIV = 1, tx_data = 0x3C, back-to-back start_valid held high → two frames of 17 cycles each; second accept 2 cycles after first rx_valid; both rx_data = 0x3C (loopback).
4. abort asserted in the 4th HIGH phase of a 0xFF frame → next edge frame = 0, sclk = 0, no rx_valid; rx_data keeps its prior value 0xA5; start_ready returns 1 after abort deasserts.
5. clr pulsed for 1 cycle mid-frame (bit 5) → all outputs 0 immediately (asynchronous); next frame with 0x5A completes normally with rx_data = 0x5A.
6. start_valid asserted while busy with tx_data = 0x00 → ignored; current frame 0xC3 completes unchanged; start_ready stays 0 until IDLE.

Source files
------------

// File: rtl/serial_shift_ctrl_pkg.sv
// Shared types and constants for the serial frame controller.
package serial_shift_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, DONE} state_t;

  localparam bit DIR_MSB_FIRST = 1'b0;
  localparam bit DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/Shiftreg.sv
// Parallel-load shift register primitive; DIRECTION 0 shifts toward the MSB
// (serial input enters at bit 0), DIRECTION 1 shifts toward the LSB.
module Shiftreg #(
  parameter int WIDTH     = 8,
  parameter int DIRECTION = 0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)     q <= '0;
    else if (load) q <= d;
    else if (en) begin
      if (DIRECTION == 1) q <= {si, q[WIDTH-1:1]};
      else                q <= {q[WIDTH-2:0], si};
    end
  end

endmodule

// File: rtl/serial_shift_ctrl.sv
// SPI-mode-0 style full-duplex frame engine: loads a word, runs WIDTH sclk
// periods with a trailing CS hold, then presents the received word.
module serial_shift_ctrl
  import serial_shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 2,
  parameter int DIRECTION = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             abort,
  output logic             sclk,
  output logic             sdo,
  input  logic             sdi,
  output logic             frame,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int DCW  = $clog2(DIV + 1);
  localparam int BCW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int HEAD = (DIRECTION == int'(DIR_LSB_FIRST)) ? 0 : WIDTH - 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  state_t           state;
  logic [DCW-1:0]   div_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic             rdy_q;
  logic             accept, div_last, in_frame, kill, tx_en, rx_en;
  logic [WIDTH-1:0] tx_q, rx_q;

  assign div_last    = (div_cnt == DIV_LAST);
  assign in_frame    = (state == LOW) || (state == HIGH) || (state == HOLD);
  assign kill        = in_frame && abort;
  assign start_ready = rdy_q && !abort;
  assign accept      = start_valid && start_ready;

  // rx samples on the sclk rising edge; tx advances on the falling edge,
  // except after the last bit where the line is parked low for HOLD.
  assign rx_en = (state == LOW)  && div_last && !abort;
  assign tx_en = (state == HIGH) && div_last && !abort && (bit_cnt != BIT_LAST);

  assign sdo = ((state == LOW) || (state == HIGH)) && tx_q[HEAD];

  Shiftreg #(.WIDTH(WIDTH), .DIRECTION(DIRECTION)) u_tx (
    .clk  (clk),
    .clrn (~clr),
    .load (accept),
    .en   (tx_en),
    .d    (tx_data),
    .si   (1'b0),
    .q    (tx_q)
  );

  Shiftreg #(.WIDTH(WIDTH), .DIRECTION(DIRECTION)) u_rx (
    .clk  (clk),
    .clrn (~clr),
    .load (accept),
    .en   (rx_en),
    .d    ({WIDTH{1'b0}}),
    .si   (sdi),
    .q    (rx_q)
  );

  // rdy_q trails IDLE by a cycle so a new accept lands two cycles after rx_valid.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      rdy_q    <= 1'b0;
      sclk     <= 1'b0;
      frame    <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rdy_q    <= (state == IDLE) && !accept;
      if (kill) begin
        state   <= IDLE;
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
        frame   <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            state   <= LOW;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame   <= 1'b1;
            busy    <= 1'b1;
          end
          LOW: begin
            if (div_last) begin
              state   <= HIGH;
              div_cnt <= '0;
              sclk    <= 1'b1;
            end else div_cnt <= div_cnt + 1'b1;
          end
          HIGH: begin
            if (div_last) begin
              div_cnt <= '0;
              sclk    <= 1'b0;
              if (bit_cnt == BIT_LAST) state <= HOLD;
              else begin
                state   <= LOW;
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else div_cnt <= div_cnt + 1'b1;
          end
          HOLD: begin
            if (div_last) begin
              state   <= DONE;
              div_cnt <= '0;
              frame   <= 1'b0;
            end else div_cnt <= div_cnt + 1'b1;
          end
          DONE: begin
            state    <= IDLE;
            busy     <= 1'b0;
            rx_valid <= 1'b1;
            rx_data  <= rx_q;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
